store_write_buffer: RTL and testbench
=====================================

// Module: store_write_buffer
// PURPOSE
//  Posted-write FIFO between the MEM stage and the single-port data memory.
//  Stores retire into the buffer in one cycle; the buffer drains one entry
//  per cycle into the memory whenever the port is not needed by a load.
//  Loads see every buffered store: the youngest matching entry is forwarded,
//  otherwise memory read data passes through.
// PARAMETERS
//  DataWidth  32  width of addresses, data and memory port
//  Depth      4   number of buffer entries; power of 2, >= 2
// PORTS
//  clk          in   1          clock; all state updates on rising edge
//  RST          in   1          asynchronous, active-low reset
//  st_valid     in   1          store request from MEM stage
//  st_addr      in   DataWidth  store word address
//  st_data      in   DataWidth  store data
//  st_ready     out  1          buffer can accept a store (not full)
//  ld_active    in   1          MEM stage performing a load this cycle
//  ld_addr      in   DataWidth  load word address
//  ld_data      out  DataWidth  load result (forwarded or memory)
//  ld_fwd       out  1          ld_data came from a buffer entry
//  mem_addr     out  DataWidth  address to data memory
//  mem_wrdata   out  DataWidth  write data to data memory
//  mem_wren     out  1          write enable to data memory
//  mem_rddata   in   DataWidth  combinational read data from data memory
//  buf_empty    out  1          no entries held
//  buf_count    out  $clog2(Depth)+1  entries held
// BEHAVIOUR
//  Reset (RST low, async): wr_ptr=rd_ptr=0, count=0, all entry valid bits 0;
//   st_ready=1, buf_empty=1, buf_count=0, mem_wren=0, ld_fwd=0.
//  Storage: circular FIFO, wr_ptr/rd_ptr wrap from Depth-1 to 0; count
//   register tracks occupancy; full = (count==Depth).
//  Push: st_valid && st_ready at rising edge writes {addr,data} at wr_ptr,
//   wr_ptr++, count++. st_ready = !full, from registered state only.
//   st_valid while full: ignored, no state change; MEM stage must stall.
//  Drain (comb. port mux): if ld_active: mem_addr=ld_addr, mem_wren=0.
//   Else if !buf_empty: mem_addr/mem_wrdata=head entry, mem_wren=1; at the
//   edge rd_ptr++, count--. Else mem_wren=0, mem_addr=ld_addr.
//   Loads always win the port; a drain never occurs in a ld_active cycle.
//  Simultaneous push+drain: count unchanged, both pointers advance. When
//   full, push is refused even if a drain happens that cycle (st_ready=0).
//  Forwarding (comb.): compare ld_addr with all held entries; the youngest
//   match (nearest wr_ptr-1) supplies ld_data, ld_fwd=1; no match:
//   ld_data=mem_rddata, ld_fwd=0. A store pushed in the same cycle is NOT
//   visible to that cycle's load. ld_fwd=0 when ld_active=0.
//  Ordering: memory writes occur in exact push order; same-address stores
//   all drain, last one wins in memory.
//  Reset mid-operation discards all buffered stores (no drain).
//  Latency: store-to-memory >= 1 cycle after push; load result same cycle.
// TESTING
//  1 Reset, push A=0x10/D=0xAA, ld_active=0 -> next cycle mem_wren=1,
//    mem_addr=0x10, mem_wrdata=0xAA; following cycle buf_empty=1.
//  2 Hold ld_active=1, push 4 stores -> buf_count=4, st_ready=0; 5th
//    st_valid ignored; drop ld_active -> 4 writes in push order, 1/cycle.
//  3 Push 0x20=0x1 then 0x20=0x2, load 0x20 with ld_active -> ld_data=0x2,
//    ld_fwd=1; load 0x24 -> ld_data=mem_rddata, ld_fwd=0.
//  4 Count=3, push and drain same cycle -> count stays 3; wr_ptr wraps
//    through Depth-1 -> 0 with data intact over 10 mixed push/drains.
//  5 Count=2, assert RST low mid-cycle -> immediately buf_empty=1,
//    mem_wren=0, st_ready=1; no stale write after release.
//  6 Random push/load stream vs reference memory model -> every ld_data
//    equals model value; final memory matches after drain.

Source files
------------

// File: rtl/store_write_buffer.sv
// store_write_buffer: posted-write FIFO between MEM stage and single-port data memory,
// draining one store per idle port cycle and forwarding the youngest matching store to loads.
module store_write_buffer #(
  parameter int DataWidth = 32,
  parameter int Depth     = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       st_valid_i,
  input  logic [DataWidth-1:0]       st_addr_i,
  input  logic [DataWidth-1:0]       st_data_i,
  output logic                       st_ready_o,
  input  logic                       ld_active_i,
  input  logic [DataWidth-1:0]       ld_addr_i,
  output logic [DataWidth-1:0]       ld_data_o,
  output logic                       ld_fwd_o,
  output logic [DataWidth-1:0]       mem_addr_o,
  output logic [DataWidth-1:0]       mem_wrdata_o,
  output logic                       mem_wren_o,
  input  logic [DataWidth-1:0]       mem_rddata_i,
  output logic                       buf_empty_o,
  output logic [$clog2(Depth):0]     buf_count_o
);
  localparam int AW = $clog2(Depth);
  logic [DataWidth-1:0] addr_q [Depth];
  logic [DataWidth-1:0] data_q [Depth];
  logic [Depth-1:0]     vld_q;
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q, idx;
  logic [AW:0]          count_q, count_d;
  logic                 full, empty, push, drain, hit;
  logic [DataWidth-1:0] fwd_data;
  assign full         = count_q == (AW+1)'(Depth);
  assign empty        = count_q == '0;
  assign push         = st_valid_i && !full;
  assign drain        = !ld_active_i && !empty;
  assign count_d      = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, drain};
  assign st_ready_o   = !full;
  assign buf_empty_o  = empty;
  assign buf_count_o  = count_q;
  assign mem_wren_o   = drain;
  assign mem_addr_o   = drain ? addr_q[rd_ptr_q] : ld_addr_i;
  assign mem_wrdata_o = data_q[rd_ptr_q];
  assign ld_fwd_o     = ld_active_i && hit;
  assign ld_data_o    = ld_fwd_o ? fwd_data : mem_rddata_i;
  // Scan oldest to youngest so the last match seen is the youngest store.
  always_comb begin
    hit      = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < Depth; i++) begin
      idx = rd_ptr_q + AW'(i);
      if (vld_q[idx] && addr_q[idx] == ld_addr_i) begin
        hit      = 1'b1;
        fwd_data = data_q[idx];
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        addr_q[wr_ptr_q] <= st_addr_i;
        data_q[wr_ptr_q] <= st_data_i;
        vld_q[wr_ptr_q]  <= 1'b1;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (drain) begin
        vld_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q        <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_store_write_buffer.sv
// tb_store_write_buffer: random and directed stimulus against a queue-plus-memory reference model.
module tb_store_write_buffer;
  localparam int DW = 32;
  localparam int DEPTH = 4;
  logic          clk = 1'b0;
  logic          rst_n;
  logic          st_valid, st_ready, ld_active, ld_fwd, mem_wren, buf_empty;
  logic [DW-1:0] st_addr, st_data, ld_addr, ld_data, mem_addr, mem_wrdata, mem_rddata;
  logic [2:0]    buf_count;
  logic [DW-1:0] mem [64];
  logic [DW-1:0] ref_mem [64];
  logic [DW-1:0] qa [$];
  logic [DW-1:0] qd [$];
  int            n_cmp = 0, n_bad = 0;

  store_write_buffer #(.DataWidth(DW), .Depth(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid_i(st_valid), .st_addr_i(st_addr), .st_data_i(st_data), .st_ready_o(st_ready),
    .ld_active_i(ld_active), .ld_addr_i(ld_addr), .ld_data_o(ld_data), .ld_fwd_o(ld_fwd),
    .mem_addr_o(mem_addr), .mem_wrdata_o(mem_wrdata), .mem_wren_o(mem_wren),
    .mem_rddata_i(mem_rddata), .buf_empty_o(buf_empty), .buf_count_o(buf_count)
  );

  always #5 clk = ~clk;
  assign mem_rddata = mem[mem_addr[5:0]];
  always @(posedge clk) if (mem_wren) mem[mem_addr[5:0]] <= mem_wrdata;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle from a negedge, check the combinational view, then advance the model.
  task automatic step(input logic sv, input logic [DW-1:0] sa, input logic [DW-1:0] sd,
                      input logic la, input logic [DW-1:0] lad);
    logic          exp_fwd, exp_wren, do_push;
    logic [DW-1:0] exp_ld;
    st_valid = sv; st_addr = sa; st_data = sd; ld_active = la; ld_addr = lad;
    #1;
    exp_fwd = 1'b0;
    exp_ld  = ref_mem[lad[5:0]];
    if (la)
      for (int i = qa.size() - 1; i >= 0; i--)
        if (!exp_fwd && qa[i] == lad) begin exp_fwd = 1'b1; exp_ld = qd[i]; end
    exp_wren = !la && qa.size() > 0;
    do_push  = sv && qa.size() < DEPTH;
    chk("st_ready", st_ready, qa.size() < DEPTH);
    chk("buf_count", buf_count, qa.size());
    chk("buf_empty", buf_empty, qa.size() == 0);
    chk("ld_fwd", ld_fwd, exp_fwd);
    if (la) chk("ld_data", ld_data, exp_ld);
    chk("mem_wren", mem_wren, exp_wren);
    if (exp_wren) begin
      chk("mem_addr", mem_addr, qa[0]);
      chk("mem_wrdata", mem_wrdata, qd[0]);
      ref_mem[qa[0][5:0]] = qd[0];
      void'(qa.pop_front());
      void'(qd.pop_front());
    end else if (la) chk("mem_addr_ld", mem_addr, lad);
    if (do_push) begin qa.push_back(sa); qd.push_back(sd); end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    rst_n = 1'b0; st_valid = 0; st_addr = 0; st_data = 0; ld_active = 0; ld_addr = 0;
    #12;
    chk("rst_ready", st_ready, 1);
    chk("rst_empty", buf_empty, 1);
    chk("rst_count", buf_count, 0);
    chk("rst_wren", mem_wren, 0);
    chk("rst_fwd", ld_fwd, 0);
    @(negedge clk); rst_n = 1'b1;
    // single store drains next cycle
    step(1, 32'h10, 32'hAA, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("t1_mem", mem[6'h10], 32'hAA);
    // fill while loads hold the port, 5th refused, then drain in order
    for (int i = 0; i < 5; i++) step(1, DW'(i + 1), DW'(32'h100 + i), 1, 32'h3F);
    chk("t2_count", buf_count, 4);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
    // youngest same-address forwarding and a miss
    step(1, 32'h20, 32'h1, 1, 32'h24);
    step(1, 32'h20, 32'h2, 1, 32'h20);
    chk("t3_fwd_data", ld_data, 32'h2);
    step(0, 0, 0, 1, 32'h20);
    step(0, 0, 0, 1, 32'h24);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    // count=3 then concurrent push/drain with pointer wrap
    for (int i = 0; i < 3; i++) step(1, DW'(8 + i), DW'(32'h200 + i), 1, 0);
    for (int i = 0; i < 10; i++) step(1, DW'(12 + i), DW'(32'h300 + i), 0, 0);
    chk("t4_count", buf_count, 3);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
    // reset mid-cycle with 2 entries held
    step(1, 32'h30, 32'h5A, 1, 0);
    step(1, 32'h31, 32'h5B, 1, 0);
    st_valid = 0; ld_active = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_empty", buf_empty, 1);
    chk("t5_wren", mem_wren, 0);
    chk("t5_ready", st_ready, 1);
    qa.delete(); qd.delete();
    @(negedge clk); rst_n = 1'b1;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("t5_no_stale", mem[6'h30], 32'h0);
    // random stream
    for (int n = 0; n < 2000; n++)
      step($urandom_range(0, 99) < 60, DW'($urandom_range(0, 15)), $urandom,
           $urandom_range(0, 99) < 50, DW'($urandom_range(0, 15)));
    for (int i = 0; i < DEPTH + 1; i++) step(0, 0, 0, 0, 0);
    chk("final_empty", buf_empty, 1);
    for (int i = 0; i < 64; i++) chk("final_mem", mem[i], ref_mem[i]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
